// File: rtl/reg_file_sb.sv
// 32x32 register file with per-register pending-write scoreboard.
// Tracks outstanding writes, raises stall on hazards, flags protocol errors.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-low reset
//   RSaddr_i    read port A address
//   RTaddr_i    read port B address
//   RSdata_o    read port A data (combinational, write-through bypass)
//   RTdata_o    read port B data (combinational, write-through bypass)
//   RegWrite_i  writeback enable; also retires one pending write to RDaddr_i
//   RDaddr_i    writeback destination
//   RDdata_i    writeback data
//   rs_used_i   decoding instruction reads RSaddr_i
//   rt_used_i   decoding instruction reads RTaddr_i
//   issue_i     decoding instruction issues and will later write issue_rd_i
//   issue_rd_i  destination reserved at issue
//   stall_o     decoding instruction must hold
//   err_o       sticky protocol-error flag (retire with nothing pending)
module reg_file_sb #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    output logic [31:0] RSdata_o,
    output logic [31:0] RTdata_o,
    input  logic        RegWrite_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [31:0] RDdata_i,
    input  logic        rs_used_i,
    input  logic        rt_used_i,
    input  logic        issue_i,
    input  logic [4:0]  issue_rd_i,
    output logic        stall_o,
    output logic        err_o
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

    logic [31:0] regs [32];
    logic [1:0]  cnt  [32];
    logic        err_q;

    logic        retire;
    logic [31:0] busy;
    logic [1:0]  issue_cnt;
    logic        issue_ret;
    logic [1:0]  issue_eff;
    logic        full;
    logic        accept;
    logic        same_rd;

    // Writes to r0 are dropped entirely, so they never retire anything.
    assign retire  = RegWrite_i && (RDaddr_i != 5'd0);
    assign same_rd = (issue_rd_i == RDaddr_i);

    // A register whose last pending write retires this cycle is readable
    // now through the bypass, so it is not considered busy.
    always_comb begin
        busy = '0;
        for (int r = 0; r < 32; r++) begin
            busy[r] = (cnt[r] != 2'd0) &&
                      !(retire && (RDaddr_i == 5'(r)) && (cnt[r] == 2'd1));
        end
    end

    // Saturation is judged on the count after a same-cycle retire, so an
    // issue to a full register can proceed when one of its writes drains.
    always_comb begin
        issue_cnt = cnt[issue_rd_i];
        issue_ret = retire && same_rd && (issue_cnt != 2'd0);
        issue_eff = issue_cnt - {1'b0, issue_ret};
        full      = issue_i && (issue_rd_i != 5'd0) && (issue_eff == CNT_MAX);
    end

    assign stall_o = (rs_used_i && busy[RSaddr_i]) ||
                     (rt_used_i && busy[RTaddr_i]) ||
                     full;

    assign accept = issue_i && (issue_rd_i != 5'd0) && !stall_o;

    always_comb begin
        RSdata_o = regs[RSaddr_i];
        if (RSaddr_i == 5'd0) begin
            RSdata_o = '0;
        end else if (retire && (RDaddr_i == RSaddr_i)) begin
            RSdata_o = RDdata_i;
        end
    end

    always_comb begin
        RTdata_o = regs[RTaddr_i];
        if (RTaddr_i == 5'd0) begin
            RTdata_o = '0;
        end else if (retire && (RDaddr_i == RTaddr_i)) begin
            RTdata_o = RDdata_i;
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (retire) begin
                regs[RDaddr_i] <= RDdata_i;
            end
            // Issue and retire to the same register cancel out; that pair
            // is never an error even when nothing was pending.
            if (retire && !(accept && same_rd)) begin
                if (cnt[RDaddr_i] == 2'd0) begin
                    err_q <= 1'b1;
                end else begin
                    cnt[RDaddr_i] <= cnt[RDaddr_i] - 2'd1;
                end
            end
            if (accept && !(retire && same_rd)) begin
                cnt[issue_rd_i] <= cnt[issue_rd_i] + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_reg_file_sb;

    localparam int MAX = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic        RegWrite_i;
    logic [4:0]  RDaddr_i;
    logic [31:0] RDdata_i;
    logic        rs_used_i;
    logic        rt_used_i;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic        stall_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;

    reg_file_sb #(.MAX_INFLIGHT(MAX)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .RSaddr_i   (RSaddr_i),
        .RTaddr_i   (RTaddr_i),
        .RSdata_o   (RSdata_o),
        .RTdata_o   (RTdata_o),
        .RegWrite_i (RegWrite_i),
        .RDaddr_i   (RDaddr_i),
        .RDdata_i   (RDdata_i),
        .rs_used_i  (rs_used_i),
        .rt_used_i  (rt_used_i),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .stall_o    (stall_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_ret();
        return RegWrite_i && (RDaddr_i != 0);
    endfunction

    function automatic bit m_busy(input int r);
        if (m_cnt[r] == 0) return 1'b0;
        if (m_ret() && RDaddr_i == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        int eff;
        eff = m_cnt[issue_rd_i];
        if (m_ret() && RDaddr_i == issue_rd_i && eff > 0) eff--;
        return (rs_used_i && m_busy(RSaddr_i)) ||
               (rt_used_i && m_busy(RTaddr_i)) ||
               (issue_i && issue_rd_i != 0 && eff == MAX);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (m_ret() && RDaddr_i == a) return RDdata_i;
        return m_reg[a];
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit acc;
        bit ret;
        if (!rst_i) begin
            m_clear();
            return;
        end
        acc = issue_i && issue_rd_i != 0 && !m_stall();
        ret = m_ret();
        if (ret) m_reg[RDaddr_i] = RDdata_i;
        if (acc) m_cnt[issue_rd_i]++;
        if (ret) begin
            if (acc && issue_rd_i == RDaddr_i) m_cnt[RDaddr_i]--;
            else if (m_cnt[RDaddr_i] == 0) m_err = 1'b1;
            else m_cnt[RDaddr_i]--;
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are checked
    // mid-cycle, then the model advances with the DUT on the rising edge.
    task automatic cycle();
        #1;
        check("rs_data", RSdata_o, m_read(RSaddr_i));
        check("rt_data", RTdata_o, m_read(RTaddr_i));
        check("stall", 32'(stall_o), 32'(m_stall()));
        check("err", 32'(err_o), 32'(m_err));
        @(posedge clk_i);
        m_update();
        @(negedge clk_i);
    endtask

    task automatic idle();
        rst_i      = 1'b1;
        RSaddr_i   = '0;
        RTaddr_i   = '0;
        RegWrite_i = 1'b0;
        RDaddr_i   = '0;
        RDdata_i   = '0;
        rs_used_i  = 1'b0;
        rt_used_i  = 1'b0;
        issue_i    = 1'b0;
        issue_rd_i = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        idle();
        issue_i    = 1'b1;
        issue_rd_i = rd;
    endtask

    task automatic do_retire(input logic [4:0] rd, input logic [31:0] d);
        idle();
        RegWrite_i = 1'b1;
        RDaddr_i   = rd;
        RDdata_i   = d;
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        m_clear();
        @(negedge clk_i);

        // Reset state
        idle();
        RSaddr_i = 5'd7;
        RTaddr_i = 5'd12;
        #1;
        check("rst_rs", RSdata_o, 32'h0);
        check("rst_rt", RTdata_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        cycle();

        // Write bypass on r5
        do_issue(5'd5);
        cycle();
        do_retire(5'd5, 32'h1234_5678);
        RSaddr_i = 5'd5;
        #1;
        check("byp_same", RSdata_o, 32'h1234_5678);
        cycle();
        idle();
        RSaddr_i = 5'd5;
        #1;
        check("byp_after", RSdata_o, 32'h1234_5678);
        cycle();

        // Load-use stall on r8
        do_issue(5'd8);
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            rs_used_i = 1'b1;
            RSaddr_i  = 5'd8;
            #1;
            check("lu_stall", 32'(stall_o), 32'h1);
            cycle();
        end
        do_retire(5'd8, 32'hCAFE_0008);
        rs_used_i = 1'b1;
        RSaddr_i  = 5'd8;
        #1;
        check("lu_release", 32'(stall_o), 32'h0);
        check("lu_data", RSdata_o, 32'hCAFE_0008);
        cycle();

        // Saturation on r9
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd9);
            #1;
            check("sat_acc", 32'(stall_o), 32'h0);
            cycle();
        end
        do_issue(5'd9);
        #1;
        check("sat_full", 32'(stall_o), 32'h1);
        cycle();
        do_issue(5'd9);
        #1;
        check("sat_hold", 32'(stall_o), 32'h1);
        cycle();
        do_issue(5'd9);
        RegWrite_i = 1'b1;
        RDaddr_i   = 5'd9;
        RDdata_i   = 32'h0000_0099;
        #1;
        check("sat_ret_acc", 32'(stall_o), 32'h0);
        cycle();
        do_issue(5'd9);
        #1;
        check("sat_still3", 32'(stall_o), 32'h1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            do_retire(5'd9, 32'h9000_0000 + 32'(i));
            cycle();
        end
        idle();
        rs_used_i = 1'b1;
        RSaddr_i  = 5'd9;
        #1;
        check("sat_drained", 32'(stall_o), 32'h0);
        cycle();

        // Zero register
        do_issue(5'd0);
        RegWrite_i = 1'b1;
        RDaddr_i   = 5'd0;
        RDdata_i   = 32'hFFFF_FFFF;
        rs_used_i  = 1'b1;
        RSaddr_i   = 5'd0;
        #1;
        check("r0_data", RSdata_o, 32'h0);
        check("r0_stall", 32'(stall_o), 32'h0);
        cycle();
        idle();
        rs_used_i = 1'b1;
        #1;
        check("r0_err", 32'(err_o), 32'h0);
        check("r0_after", RSdata_o, 32'h0);
        cycle();

        // Error and reset
        do_issue(5'd4);
        cycle();
        do_retire(5'd3, 32'h3333_3333);
        cycle();
        idle();
        #1;
        check("err_set", 32'(err_o), 32'h1);
        cycle();
        idle();
        #1;
        check("err_sticky", 32'(err_o), 32'h1);
        cycle();
        idle();
        rst_i = 1'b0;
        cycle();
        idle();
        rs_used_i = 1'b1;
        RSaddr_i  = 5'd4;
        RTaddr_i  = 5'd5;
        #1;
        check("rst2_err", 32'(err_o), 32'h0);
        check("rst2_busy", 32'(stall_o), 32'h0);
        check("rst2_rs", RSdata_o, 32'h0);
        check("rst2_rt", RTdata_o, 32'h0);
        cycle();
        do_retire(5'd4, 32'h4444_4444);
        cycle();
        idle();
        #1;
        check("rst2_stale", 32'(err_o), 32'h1);
        cycle();

        // Randomized traffic on a narrow address range for dense hazards
        for (int n = 0; n < 3000; n++) begin
            int pick;
            idle();
            rst_i      = ($urandom_range(0, 199) != 0);
            RSaddr_i   = 5'($urandom_range(0, 7));
            RTaddr_i   = 5'($urandom_range(0, 7));
            rs_used_i  = 1'($urandom);
            rt_used_i  = 1'($urandom);
            issue_i    = 1'($urandom);
            issue_rd_i = 5'($urandom_range(0, 7));
            RegWrite_i = ($urandom_range(0, 2) != 0);
            RDdata_i   = $urandom;
            pick       = $urandom_range(0, 7);
            RDaddr_i   = 5'(pick);
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_cnt[(pick + k) % 8] > 0) begin
                        RDaddr_i = 5'((pick + k) % 8);
                        break;
                    end
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
